mdu_sequencer: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers and its sequencing and stall control, in the EX stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the control-unit decode (mduOp, start).
- Models fixed multiply and divide latencies with a busy counter.
- Produces the stall request the hazard unit ORs into its D-stage freeze.

---
 rtl/mdu_sequencer.sv | 130 +++++++++++++
 tb/tb_mdu_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// EX-stage multiply/divide unit: owns HI/LO, models fixed mult/div latency with
// a busy counter and raises the D-stage stall for dependent md/mt/mf instructions.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [4:0]  i_mduOp,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  input  logic        i_d_is_mdu,
  output logic        o_busy,
  output logic        o_stall,
  output logic [31:0] o_result,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MTLO  = 5'd5;
  localparam logic [4:0] OP_MTHI  = 5'd6;
  localparam logic [4:0] OP_MFLO  = 5'd7;
  localparam logic [4:0] OP_MFHI  = 5'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi, lo, pend_hi, pend_lo;
  logic             pend_we;

  logic             is_mul, is_div, start_ok;
  logic signed [63:0] a_s64, b_s64, prod_s;
  logic [63:0]      prod_u;
  logic signed [31:0] a_s, b_s, q_s, r_s;
  logic [31:0]      b_nz, q_u, r_u;
  logic [31:0]      res_hi, res_lo;
  logic             res_we;

  assign is_mul   = (i_mduOp == OP_MULT) || (i_mduOp == OP_MULTU);
  assign is_div   = (i_mduOp == OP_DIV)  || (i_mduOp == OP_DIVU);
  assign start_ok = i_start && (is_mul || is_div);

  always_comb begin
    a_s64  = {{32{i_A[31]}}, i_A};
    b_s64  = {{32{i_B[31]}}, i_B};
    prod_s = a_s64 * b_s64;
    prod_u = {32'b0, i_A} * {32'b0, i_B};
    // Divisor forced non-zero so the divider never sees x/0; the result is discarded anyway.
    b_nz   = (i_B == 32'd0) ? 32'd1 : i_B;
    a_s    = $signed(i_A);
    b_s    = $signed(b_nz);
    q_s    = a_s / b_s;
    r_s    = a_s % b_s;
    if (i_A == 32'h8000_0000 && i_B == 32'hFFFF_FFFF) begin
      q_s = 32'sh8000_0000;
      r_s = 32'sd0;
    end
    q_u    = i_A / b_nz;
    r_u    = i_A % b_nz;
    res_we = 1'b1;
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (i_mduOp)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   begin res_hi = r_s; res_lo = q_s; res_we = (i_B != 32'd0); end
      OP_DIVU:  begin res_hi = r_u; res_lo = q_u; res_we = (i_B != 32'd0); end
      default:  res_we = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_we <= res_we;
            cnt     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state   <= S_BUSY;
          end else if (i_mduOp == OP_MTHI) begin
            hi <= i_A;
          end else if (i_mduOp == OP_MTLO) begin
            lo <= i_A;
          end
        end
        S_BUSY: begin
          // New starts and MT writes are ignored until the commit edge.
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            if (pend_we) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_busy  = (state == S_BUSY);
  assign o_stall = i_d_is_mdu & (i_start | o_busy);
  assign o_hi    = hi;
  assign o_lo    = lo;

  always_comb begin
    o_result = 32'd0;
    if (i_mduOp == OP_MFHI)      o_result = hi;
    else if (i_mduOp == OP_MFLO) o_result = lo;
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: expected HI/LO queued at issue, checked at commit.
module tb_mdu_sequencer;

  localparam logic [4:0] OP_NONE  = 5'd0;
  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MTLO  = 5'd5;
  localparam logic [4:0] OP_MTHI  = 5'd6;
  localparam logic [4:0] OP_MFLO  = 5'd7;
  localparam logic [4:0] OP_MFHI  = 5'd8;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_start, i_d_is_mdu;
  logic [4:0]  i_mduOp;
  logic [31:0] i_A, i_B;
  logic        o_busy, o_stall;
  logic [31:0] o_result, o_hi, o_lo;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] sb[$];

  always #5 i_clk = ~i_clk;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mduOp(i_mduOp),
    .i_A(i_A), .i_B(i_B), .i_d_is_mdu(i_d_is_mdu), .o_busy(o_busy),
    .o_stall(o_stall), .o_result(o_result), .o_hi(o_hi), .o_lo(o_lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one mult/div, count busy cycles, then compare HI/LO against the queued result.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic d, input int n,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int repulse, input logic mt_junk);
    int cyc;
    logic [31:0] prev_lo;
    logic [63:0] exp;
    @(negedge i_clk);
    i_mduOp = op; i_A = a; i_B = b; i_start = 1'b1; i_d_is_mdu = d;
    sb.push_back({ehi, elo});
    #1;
    chk({tag, "_stall_start"}, {31'b0, o_stall}, {31'b0, d});
    prev_lo = o_lo;
    @(negedge i_clk);
    cyc = 0;
    for (int k = 0; k < 64; k++) begin
      if (!o_busy) break;
      cyc++;
      chk({tag, "_stall_busy"}, {31'b0, o_stall}, {31'b0, d});
      if (mt_junk && cyc == 2) chk({tag, "_lo_mt_ignored"}, o_lo, prev_lo);
      i_start = 1'b0; i_mduOp = OP_NONE; i_A = 32'd0; i_B = 32'd0;
      if (cyc == repulse) begin
        i_start = 1'b1; i_mduOp = OP_DIVU; i_A = 32'd100; i_B = 32'd7;
      end
      if (mt_junk && cyc == 1) begin
        i_mduOp = OP_MTLO; i_A = 32'hBAD0_BAD0;
      end
      @(negedge i_clk);
    end
    i_start = 1'b0; i_mduOp = OP_NONE; i_A = 32'd0; i_B = 32'd0;
    #1;
    chk({tag, "_busy_cycles"}, 32'(cyc), 32'(n));
    chk({tag, "_stall_after"}, {31'b0, o_stall}, 32'd0);
    exp = sb.pop_front();
    chk({tag, "_hi"}, o_hi, exp[63:32]);
    chk({tag, "_lo"}, o_lo, exp[31:0]);
  endtask

  task automatic mt(input logic [4:0] op, input logic [31:0] v);
    @(negedge i_clk);
    i_mduOp = op; i_A = v; i_d_is_mdu = 1'b1;
    @(negedge i_clk);
    i_mduOp = OP_NONE; i_A = 32'd0;
    #1;
    chk("mt_no_busy", {31'b0, o_busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] p;
    i_rst_n = 1'b0; i_start = 1'b0; i_mduOp = OP_NONE; i_A = '0; i_B = '0; i_d_is_mdu = 1'b1;
    #2;
    chk("rst_hi", o_hi, 32'd0);
    chk("rst_lo", o_lo, 32'd0);
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_stall", {31'b0, o_stall}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    run_op("mult",  OP_MULT,  32'hFFFF_FFFE, 32'd3, 1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 1'b0);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 5,  32'h0000_0002, 32'hFFFF_FFFA, 0, 1'b0);
    run_op("div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0);
    run_op("divu",  OP_DIVU,  32'd7,         32'd2, 1'b1, 10, 32'd1,         32'd3,         0, 1'b0);

    mt(OP_MTHI, 32'h11);
    mt(OP_MTLO, 32'h22);
    run_op("div0",  OP_DIV,   32'd5,         32'd0, 1'b1, 10, 32'h11,        32'h22,        0, 1'b0);
    run_op("divov", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10, 32'd0, 32'h8000_0000, 0, 1'b0);

    mt(OP_MTHI, 32'hDEAD_BEEF);
    @(negedge i_clk);
    i_mduOp = OP_MFHI; #1;
    chk("mfhi", o_result, 32'hDEAD_BEEF);
    i_mduOp = OP_MFLO; #1;
    chk("mflo", o_result, 32'h8000_0000);
    i_mduOp = OP_NONE; #1;
    chk("result_default", o_result, 32'd0);

    run_op("mt_busy", OP_MULT, 32'd7, 32'd6, 1'b1, 5, 32'd0, 32'd42, 0, 1'b1);
    run_op("repulse", OP_MULT, 32'h0001_0000, 32'h0001_0000, 1'b1, 5, 32'd1, 32'd0, 2, 1'b0);

    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      p = {32'b0, ra} * {32'b0, rb};
      run_op("rnd_multu", OP_MULTU, ra, rb, 1'b0, 5, p[63:32], p[31:0], 0, 1'b0);
      rb = rb | 32'd1;
      run_op("rnd_divu", OP_DIVU, ra, rb, 1'b1, 10, ra % rb, ra / rb, 0, 1'b0);
    end

    // Abort a DIV with async reset when four busy cycles remain.
    @(negedge i_clk);
    i_mduOp = OP_DIV; i_A = 32'd100; i_B = 32'd3; i_start = 1'b1; i_d_is_mdu = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_mduOp = OP_NONE; i_A = '0; i_B = '0;
    repeat (6) @(posedge i_clk);
    #1;
    chk("pre_abort_busy", {31'b0, o_busy}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, o_busy}, 32'd0);
    chk("abort_hi", o_hi, 32'd0);
    chk("abort_lo", o_lo, 32'd0);
    chk("abort_stall", {31'b0, o_stall}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (12) @(negedge i_clk);
    chk("post_abort_hi", o_hi, 32'd0);
    chk("post_abort_lo", o_lo, 32'd0);
    chk("post_abort_busy", {31'b0, o_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
